// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle between the control unit (master) and the
// branch resolve unit (slave).
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) ();
    logic              br_valid;
    logic              br_ready;
    logic              is_bl;
    logic [3:0]        cond;
    logic [3:0]        flags_nzcv;
    logic              flags_valid;
    logic [ADDR_W-1:0] target_in;
    logic [ADDR_W-1:0] link_in;
    logic              take;
    logic [ADDR_W-1:0] target_out;
    logic              lr_we;
    logic [ADDR_W-1:0] lr_data;
    logic              resolved;
    logic              flush;
    logic              stall;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nottaken_cnt;

    modport master (
        output br_valid, is_bl, cond, flags_nzcv, flags_valid, target_in, link_in,
        input  br_ready, take, target_out, lr_we, lr_data, resolved, flush, stall,
               taken_cnt, nottaken_cnt
    );

    modport slave (
        input  br_valid, is_bl, cond, flags_nzcv, flags_valid, target_in, link_in,
        output br_ready, take, target_out, lr_we, lr_data, resolved, flush, stall,
               taken_cnt, nottaken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves conditional B/BL: waits for valid flags, pulses take/lr_we/resolved,
// then holds flush for FLUSH_DEPTH cycles after a taken branch.
module branch_resolve_unit #(
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_flush_cnt;
    logic [3:0]        r_cond;
    logic              r_is_bl;
    logic [ADDR_W-1:0] r_target_cap;
    logic [ADDR_W-1:0] r_link_cap;
    logic              r_take;
    logic              r_lr_we;
    logic              r_resolved;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] r_lr_data;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  r_nottaken_cnt;

    logic              w_accept;
    logic              w_eval;
    logic              w_cond_true;
    logic [3:0]        w_cond_code;
    logic              w_is_bl;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_link;

    function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // In IDLE the request is evaluated straight off the bus; afterwards the captured copy is used.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_eval      = 1'b0;
        w_cond_code = r_cond;
        w_is_bl     = r_is_bl;
        w_target    = r_target_cap;
        w_link      = r_link_cap;
        unique case (r_state)
            IDLE: begin
                w_cond_code = bus.cond;
                w_is_bl     = bus.is_bl;
                w_target    = bus.target_in;
                w_link      = bus.link_in;
                if (bus.br_valid) begin
                    w_accept = 1'b1;
                    if (bus.flags_valid) w_eval = 1'b1;
                    else                 w_state_nxt = WAIT_FLAGS;
                end
            end
            WAIT_FLAGS: if (bus.flags_valid) w_eval = 1'b1;
            FLUSH:      if (r_flush_cnt == 4'd0) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
        w_cond_true = cond_holds(w_cond_code, bus.flags_nzcv);
        if (w_eval) w_state_nxt = w_cond_true ? FLUSH : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_cnt    <= '0;
            r_cond         <= '0;
            r_is_bl        <= 1'b0;
            r_target_cap   <= '0;
            r_link_cap     <= '0;
            r_take         <= 1'b0;
            r_lr_we        <= 1'b0;
            r_resolved     <= 1'b0;
            r_target       <= '0;
            r_lr_data      <= '0;
            r_taken_cnt    <= '0;
            r_nottaken_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values.
            r_take     <= 1'b0;
            r_lr_we    <= 1'b0;
            r_resolved <= 1'b0;
            if (w_accept) begin
                r_cond       <= bus.cond;
                r_is_bl      <= bus.is_bl;
                r_target_cap <= bus.target_in;
                r_link_cap   <= bus.link_in;
            end
            if (w_eval) begin
                r_resolved <= 1'b1;
                if (w_cond_true) begin
                    r_take      <= 1'b1;
                    r_target    <= w_target;
                    r_lr_we     <= w_is_bl;
                    r_flush_cnt <= FLUSH_LOAD;
                    if (w_is_bl) r_lr_data <= w_link;
                    if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 1'b1;
                end else if (r_nottaken_cnt != '1) begin
                    r_nottaken_cnt <= r_nottaken_cnt + 1'b1;
                end
            end else if (r_state == FLUSH && r_flush_cnt != 4'd0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    assign bus.br_ready     = (r_state == IDLE);
    assign bus.stall        = (r_state == WAIT_FLAGS);
    assign bus.flush        = (r_state == FLUSH);
    assign bus.take         = r_take;
    assign bus.lr_we        = r_lr_we;
    assign bus.resolved     = r_resolved;
    assign bus.target_out   = r_target;
    assign bus.lr_data      = r_lr_data;
    assign bus.taken_cnt    = r_taken_cnt;
    assign bus.nottaken_cnt = r_nottaken_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: instance A (FLUSH_DEPTH=2, CNT_W=16) for function and truth table,
// instance B (FLUSH_DEPTH=3, CNT_W=2) for flush hold-off, saturation and reset mid-flush.
module tb_branch_resolve_unit;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_W(AW), .CNT_W(16)) if_a ();
    branch_resolve_unit_if #(.ADDR_W(AW), .CNT_W(2))  if_b ();

    branch_resolve_unit #(.ADDR_W(AW), .FLUSH_DEPTH(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    branch_resolve_unit #(.ADDR_W(AW), .FLUSH_DEPTH(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    typedef struct {
        logic          take;
        logic          lr_we;
        logic [AW-1:0] tgt;
        logic [AW-1:0] link;
    } exp_t;

    exp_t          sb_a[$];
    exp_t          sb_b[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            exp_tk = 0;
    int            exp_nt = 0;
    logic [AW-1:0] last_tgt = '0;
    logic [AW-1:0] last_link = '0;

    // Reference truth table for the ARM condition field.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z == 1'b1;
            4'h1: return z == 1'b0;
            4'h2: return cy == 1'b1;
            4'h3: return cy == 1'b0;
            4'h4: return n == 1'b1;
            4'h5: return n == 1'b0;
            4'h6: return v == 1'b1;
            4'h7: return v == 1'b0;
            4'h8: return (cy == 1'b1) && (z == 1'b0);
            4'h9: return (cy == 1'b0) || (z == 1'b1);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return (z == 1'b0) && (n == v);
            4'hD: return (z == 1'b1) || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic fv, input logic bl, input logic [3:0] c,
                           input logic [3:0] f, input logic [AW-1:0] t, input logic [AW-1:0] l);
        if_a.br_valid = v; if_a.flags_valid = fv; if_a.is_bl = bl; if_a.cond = c;
        if_a.flags_nzcv = f; if_a.target_in = t; if_a.link_in = l;
    endtask

    task automatic b_drive(input logic v, input logic fv, input logic bl, input logic [3:0] c,
                           input logic [3:0] f, input logic [AW-1:0] t, input logic [AW-1:0] l);
        if_b.br_valid = v; if_b.flags_valid = fv; if_b.is_bl = bl; if_b.cond = c;
        if_b.flags_nzcv = f; if_b.target_in = t; if_b.link_in = l;
    endtask

    task automatic a_push(input logic [3:0] c, input logic [3:0] f, input logic bl,
                          input logic [AW-1:0] t, input logic [AW-1:0] l);
        exp_t e;
        e.take = ref_cond(c, f); e.lr_we = bl && e.take; e.tgt = t; e.link = l;
        sb_a.push_back(e);
    endtask

    task automatic a_wait_ready();
        int i = 0;
        while (!if_a.br_ready && i < 20) begin tick(); i++; end
        check("a_ready_bound", 64'(if_a.br_ready), 64'd1);
    endtask

    // Call in the cycle the result is expected; checks it and the scoreboard entry.
    task automatic a_resolve(input string tag);
        exp_t e;
        int   i = 0;
        while (!if_a.resolved && i < 20) begin tick(); i++; end
        check({tag, "_latency"}, 64'(i), 64'd0);
        if (!if_a.resolved || sb_a.size() == 0) begin
            n_vec++; n_err++;
            $error("FAIL %s_resolve observed=none expected=resolved", tag);
            return;
        end
        e = sb_a.pop_front();
        check({tag, "_take"},  64'(if_a.take),     64'(e.take));
        check({tag, "_lr_we"}, 64'(if_a.lr_we),    64'(e.lr_we));
        check({tag, "_ready"}, 64'(if_a.br_ready), 64'(!e.take));
        check({tag, "_flush"}, 64'(if_a.flush),    64'(e.take));
        if (e.take) begin last_tgt = e.tgt; exp_tk++; end
        else exp_nt++;
        if (e.lr_we) last_link = e.link;
        check({tag, "_target"},  64'(if_a.target_out),   64'(last_tgt));
        check({tag, "_lr_data"}, 64'(if_a.lr_data),      64'(last_link));
        check({tag, "_tk_cnt"},  64'(if_a.taken_cnt),    64'(exp_tk));
        check({tag, "_nt_cnt"},  64'(if_a.nottaken_cnt), 64'(exp_nt));
    endtask

    // Counts flush cycles from the take cycle, leaving the bench in the first cycle after.
    task automatic a_flush_len(input string tag, input int exp_len);
        int n = 0;
        while (if_a.flush && n < 20) begin n++; tick(); end
        check({tag, "_flush_len"}, 64'(n), 64'(exp_len));
        check({tag, "_ready_after"}, 64'(if_a.br_ready), 64'd1);
    endtask

    task automatic a_issue(input string tag, input logic [3:0] c, input logic [3:0] f,
                           input logic bl, input logic [AW-1:0] t, input logic [AW-1:0] l);
        a_wait_ready();
        a_drive(1'b1, 1'b1, bl, c, f, t, l);
        a_push(c, f, bl, t, l);
        tick();
        a_drive(1'b0, 1'b1, ~bl, ~c, ~f, ~t, ~l);
        a_resolve(tag);
        if (ref_cond(c, f)) a_flush_len(tag, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t eb;
        a_drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, '0, '0);
        b_drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, '0, '0);

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_ready",  64'(if_a.br_ready),     64'd1);
        check("rst_take",   64'(if_a.take),         64'd0);
        check("rst_lr_we",  64'(if_a.lr_we),        64'd0);
        check("rst_resolv", 64'(if_a.resolved),     64'd0);
        check("rst_flush",  64'(if_a.flush),        64'd0);
        check("rst_stall",  64'(if_a.stall),        64'd0);
        check("rst_target", 64'(if_a.target_out),   64'd0);
        check("rst_lrdata", 64'(if_a.lr_data),      64'd0);
        check("rst_tk",     64'(if_a.taken_cnt),    64'd0);
        check("rst_nt",     64'(if_a.nottaken_cnt), 64'd0);

        // EQ taken with link, then NE not taken
        a_issue("eq_bl", 4'h0, 4'b0100, 1'b1, 32'h100, 32'h24);
        a_issue("ne_nt", 4'h1, 4'b0100, 1'b1, 32'h180, 32'h28);

        // LT accepted while flags pending; captured cond must be used
        a_wait_ready();
        a_drive(1'b1, 1'b0, 1'b0, 4'hB, 4'b0000, 32'h200, 32'h44);
        a_push(4'hB, 4'b1000, 1'b0, 32'h200, 32'h44);
        tick();
        check("lt_stall1", 64'(if_a.stall),    64'd1);
        check("lt_ready1", 64'(if_a.br_ready), 64'd0);
        a_drive(1'b1, 1'b0, 1'b1, 4'h0, 4'b1000, 32'h999, 32'h888);
        tick();
        check("lt_stall2", 64'(if_a.stall),    64'd1);
        check("lt_resol2", 64'(if_a.resolved), 64'd0);
        tick();
        check("lt_stall3", 64'(if_a.stall),    64'd1);
        a_drive(1'b0, 1'b1, 1'b1, 4'h0, 4'b1000, 32'h999, 32'h888);
        tick();
        check("lt_stall_off", 64'(if_a.stall), 64'd0);
        a_resolve("lt_wait");
        a_flush_len("lt_wait", 2);

        // Full truth table: every code against every flag value
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                a_issue($sformatf("tt_c%0h_f%0h", c, f), 4'(c), 4'(f),
                        1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom));
            end
        end

        // Reset while waiting for flags aborts the branch
        a_wait_ready();
        a_drive(1'b1, 1'b0, 1'b1, 4'hE, 4'h0, 32'h500, 32'h504);
        tick();
        a_drive(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 32'h500, 32'h504);
        check("rw_stall", 64'(if_a.stall), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rw_stall_off", 64'(if_a.stall),     64'd0);
        check("rw_ready",     64'(if_a.br_ready),  64'd1);
        check("rw_tk_cnt",    64'(if_a.taken_cnt), 64'd0);
        if_a.flags_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rw_no_take",  64'(if_a.take),     64'd0);
            check("rw_no_lrwe",  64'(if_a.lr_we),    64'd0);
            check("rw_no_resol", 64'(if_a.resolved), 64'd0);
        end

        // Instance B: br_valid held through FLUSH_DEPTH=3, 2-bit counter saturation
        b_drive(1'b1, 1'b1, 1'b1, 4'hE, 4'h0, 32'h1000, 32'h2000);
        eb.take = 1'b1; eb.lr_we = 1'b1; eb.tgt = 32'h1000; eb.link = 32'h2000;
        sb_b.push_back(eb);
        for (int k = 0; k < 5; k++) begin
            tick();
            eb = sb_b.pop_front();
            check($sformatf("b%0d_take", k),   64'(if_b.take),       64'(eb.take));
            check($sformatf("b%0d_lrwe", k),   64'(if_b.lr_we),      64'(eb.lr_we));
            check($sformatf("b%0d_target", k), 64'(if_b.target_out), 64'(eb.tgt));
            check($sformatf("b%0d_lrdata", k), 64'(if_b.lr_data),    64'(eb.link));
            check($sformatf("b%0d_tk_cnt", k), 64'(if_b.taken_cnt),  64'((k + 1 > 3) ? 3 : k + 1));
            for (int j = 0; j < 3; j++) begin
                check($sformatf("b%0d_flush%0d", k, j), 64'(if_b.flush),    64'd1);
                check($sformatf("b%0d_block%0d", k, j), 64'(if_b.br_ready), 64'd0);
                tick();
            end
            check($sformatf("b%0d_flush_off", k), 64'(if_b.flush),    64'd0);
            check($sformatf("b%0d_ready", k),     64'(if_b.br_ready), 64'd1);
            if (k < 4) begin
                b_drive(1'b1, 1'b1, 1'b1, 4'hE, 4'h0, AW'(32'h1001 + k), AW'(32'h2001 + k));
                eb.tgt = AW'(32'h1001 + k); eb.link = AW'(32'h2001 + k);
                sb_b.push_back(eb);
            end else begin
                b_drive(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, '0, '0);
            end
        end
        tick(); tick();
        check("b_sat_hold", 64'(if_b.taken_cnt), 64'd3);
        check("b_nt_cnt",   64'(if_b.nottaken_cnt), 64'd0);

        // Instance B: reset in the middle of FLUSH
        b_drive(1'b1, 1'b1, 1'b1, 4'hE, 4'h0, 32'h3000, 32'h3004);
        tick();
        b_drive(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, '0, '0);
        check("rf_take", 64'(if_b.take), 64'd1);
        tick();
        check("rf_flush_mid", 64'(if_b.flush), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rf_flush_off", 64'(if_b.flush),      64'd0);
        check("rf_ready",     64'(if_b.br_ready),   64'd1);
        check("rf_target",    64'(if_b.target_out), 64'd0);
        check("rf_tk_cnt",    64'(if_b.taken_cnt),  64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rf_no_take",  64'(if_b.take),     64'd0);
            check("rf_no_lrwe",  64'(if_b.lr_we),    64'd0);
            check("rf_no_resol", 64'(if_b.resolved), 64'd0);
            check("rf_no_flush", 64'(if_b.flush),    64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
